// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: display read port, CPU request/response port and the shared RAM port.
// slave is the arbiter's view; master is the surrounding system (timing gen, CPU bridge, RAM).
interface vram_arbiter_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 19,
    parameter int unsigned DW    = 12
);
    localparam int unsigned PW = $clog2(DEPTH) + 1;

    logic          vga_rdn;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          cpu_err;
    logic [PW-1:0] pending;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  vga_rdn, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vga_data, cpu_ready, cpu_rdata, cpu_rvalid, cpu_err, pending,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output vga_rdn, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vga_data, cpu_ready, cpu_rdata, cpu_rvalid, cpu_err, pending,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one VRAM port: display reads win every cycle, CPU ops queue and issue on free cycles (>= 1 cycle after accept).
// CPU read data returns 2 cycles after issue; cpu_ready drops when the queue holds DEPTH entries.
module vram_arbiter #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 19,
    parameter int unsigned DW     = 12,
    parameter int unsigned PIXELS = 307200
) (
    input  logic          vga_clk,
    input  logic          rst,
    vram_arbiter_if.slave bus
);
    localparam int unsigned PTRW     = $clog2(DEPTH);
    localparam int unsigned PW       = PTRW + 1;
    localparam logic [PW-1:0] FULL   = PW'(DEPTH);
    localparam logic [AW:0] ADDR_LIM = (AW+1)'(PIXELS);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    entry_t          fifo_d [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   count_q, count_d;
    logic            rd_tag_q, rd_tag_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic            cpu_rvalid_q, cpu_rvalid_d;
    logic            cpu_err_q, cpu_err_d;

    logic   accept;
    logic   in_range;
    logic   push;
    logic   pop;
    entry_t head;
    entry_t new_entry;

    // Readiness looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign bus.cpu_ready = (count_q != FULL);
    assign accept        = bus.cpu_req && bus.cpu_ready;
    assign in_range      = ({1'b0, bus.cpu_addr} < ADDR_LIM);
    assign push          = accept && in_range;
    assign pop           = bus.vga_rdn && (count_q != '0);
    assign head          = fifo_q[rd_ptr_q];

    assign new_entry.we    = bus.cpu_we;
    assign new_entry.addr  = bus.cpu_addr;
    assign new_entry.wdata = bus.cpu_wdata;

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (!bus.vga_rdn) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.vga_addr;
        end else if (pop) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = head.we;
            bus.ram_addr  = head.addr;
            bus.ram_wdata = head.wdata;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = new_entry;
            wr_ptr_d         = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    // The RAM returns read data one cycle after issue; the tag marks that cycle as belonging to the CPU.
    always_comb begin
        rd_tag_d     = pop && !head.we;
        cpu_rvalid_d = rd_tag_q;
        cpu_rdata_d  = rd_tag_q ? bus.ram_rdata : cpu_rdata_q;
        cpu_err_d    = accept && !in_range;
    end

    always_ff @(posedge vga_clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_tag_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_tag_q     <= rd_tag_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_err_q    <= cpu_err_d;
        end
    end

    assign bus.vga_data   = bus.ram_rdata;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_err    = cpu_err_q;
    assign bus.pending    = count_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic against a queue-and-memory reference model.
module tb_vram_arbiter;
    localparam int DEPTH  = 16;
    localparam int AW     = 19;
    localparam int DW     = 12;
    localparam int PIXELS = 307200;
    localparam int PW     = $clog2(DEPTH) + 1;

    logic vga_clk = 1'b0;
    logic rst;
    always #5 vga_clk = ~vga_clk;

    vram_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    vram_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PIXELS(PIXELS)) dut (
        .vga_clk (vga_clk),
        .rst     (rst),
        .bus     (bus)
    );

    // Behavioural VRAM: synchronous, one cycle read latency.
    bit [DW-1:0] ram_mem [int];
    always @(posedge vga_clk) begin
        if (bus.ram_en === 1'b1) begin
            if (bus.ram_we === 1'b1) ram_mem[int'(bus.ram_addr)] = bus.ram_wdata;
            else bus.ram_rdata <= ram_mem.exists(int'(bus.ram_addr)) ? ram_mem[int'(bus.ram_addr)] : '0;
        end
    end

    // Reference model: request queue in acceptance order plus the memory contents it implies.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    req_t        q [$];
    bit [DW-1:0] mref [int];

    logic          rv_now, rv_nxt, err_now, err_nxt, tag_now, tag_nxt, vgav_now, vgav_nxt;
    logic [DW-1:0] rdata_now, rdata_nxt, tagd_now, tagd_nxt, vga_now, vga_nxt;
    logic          e_ready, e_en, e_we, accepted;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    int            e_pending;
    int            n_run, n_fail;

    function automatic logic [DW-1:0] mref_rd(input logic [AW-1:0] a);
        return mref.exists(int'(a)) ? mref[int'(a)] : '0;
    endfunction

    task automatic model_clear();
        q.delete();
        rv_now = 0; rv_nxt = 0; err_now = 0; err_nxt = 0; tag_now = 0; tag_nxt = 0;
        vgav_now = 0; vgav_nxt = 0; rdata_now = '0; rdata_nxt = '0;
        tagd_now = '0; tagd_nxt = '0; vga_now = '0; vga_nxt = '0;
    endtask

    task automatic set_idle();
        bus.vga_rdn = 1'b1; bus.vga_addr = '0; bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    endtask

    // One clock cycle: drive inputs after the rising edge, derive this cycle's expectations, return at the falling edge.
    task automatic tick(input logic rdn, input logic [AW-1:0] vaddr, input logic req, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_t h;
        req_t r;
        @(posedge vga_clk); #1;
        rv_now = rv_nxt; err_now = err_nxt; tag_now = tag_nxt; rdata_now = rdata_nxt;
        tagd_now = tagd_nxt; vga_now = vga_nxt; vgav_now = vgav_nxt;
        bus.vga_rdn = rdn; bus.vga_addr = vaddr; bus.cpu_req = req;
        bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        e_pending = q.size();
        e_ready   = (q.size() != DEPTH);
        e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        rv_nxt    = tag_now;
        rdata_nxt = tag_now ? tagd_now : rdata_now;
        tag_nxt = 0; tagd_nxt = '0; vgav_nxt = 0; vga_nxt = '0;
        if (!rdn) begin
            e_en = 1; e_addr = vaddr;
            vgav_nxt = 1; vga_nxt = mref_rd(vaddr);
        end else if (q.size() > 0) begin
            h = q.pop_front();
            e_en = 1; e_we = h.we; e_addr = h.addr; e_wdata = h.wdata;
            if (h.we) mref[int'(h.addr)] = h.wdata;
            else begin
                tag_nxt = 1; tagd_nxt = mref_rd(h.addr);
            end
        end
        accepted = req && e_ready;
        err_nxt  = accepted && (int'(addr) >= PIXELS);
        if (accepted && int'(addr) < PIXELS) begin
            r.we = we; r.addr = addr; r.wdata = wdata;
            q.push_back(r);
        end
        @(negedge vga_clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = AW'(3); bus.cpu_wdata = DW'(12'h123);
        model_clear();
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        n_run++;
        if (bus.cpu_ready !== 1'b1 || bus.pending !== PW'(0) || bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_comb: ready=%b pending=%0d ram_en=%b ram_we=%b, required 1 0 0 0",
                     bus.cpu_ready, bus.pending, bus.ram_en, bus.ram_we);
        end
        n_run++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: rvalid=%b err=%b rdata=%h, required 0 0 000",
                     bus.cpu_rvalid, bus.cpu_err, bus.cpu_rdata);
        end
        @(posedge vga_clk); #1;
        rst = 1'b0;
        set_idle();
        tick(1, '0, 0, 0, '0, '0);
        n_run++;
        if (bus.pending !== PW'(0) || bus.ram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_push: pending=%0d ram_en=%b, required 0 0", bus.pending, bus.ram_en);
        end
    endtask

    task automatic test_blank_write_read();
        tick(1, '0, 1, 1, AW'(100), DW'(12'hABC));
        n_run++;
        if (bus.ram_en !== 1'b0 || bus.pending !== PW'(0)) begin
            n_fail++;
            $display("FAIL wr_no_bypass: ram_en=%b pending=%0d, required 0 0", bus.ram_en, bus.pending);
        end
        tick(1, '0, 1, 0, AW'(100), '0);
        n_run++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== AW'(100) || bus.ram_wdata !== DW'(12'hABC)) begin
            n_fail++;
            $display("FAIL wr_issue: en=%b we=%b addr=%0d wdata=%h, required 1 1 100 abc",
                     bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        tick(1, '0, 0, 0, '0, '0);
        n_run++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== AW'(100)) begin
            n_fail++;
            $display("FAIL rd_issue: en=%b we=%b addr=%0d, required 1 0 100", bus.ram_en, bus.ram_we, bus.ram_addr);
        end
        tick(1, '0, 0, 0, '0, '0);
        n_run++;
        if (bus.cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_early: rvalid=%b one cycle after issue, required 0", bus.cpu_rvalid);
        end
        tick(1, '0, 0, 0, '0, '0);
        n_run++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== DW'(12'hABC)) begin
            n_fail++;
            $display("FAIL rd_data: rvalid=%b rdata=%h, required 1 abc", bus.cpu_rvalid, bus.cpu_rdata);
        end
        tick(1, '0, 0, 0, '0, '0);
        n_run++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== DW'(12'hABC)) begin
            n_fail++;
            $display("FAIL rd_pulse_hold: rvalid=%b rdata=%h, required 0 abc", bus.cpu_rvalid, bus.cpu_rdata);
        end
    endtask

    task automatic test_display_priority();
        logic [AW-1:0] wa [4];
        logic [DW-1:0] wd [4];
        logic [AW-1:0] va;
        int bad_addr, bad_pix;
        bad_addr = 0; bad_pix = 0;
        for (int i = 0; i < 4; i++) begin
            wa[i] = AW'(1000 + i * 7);
            wd[i] = DW'($urandom);
        end
        for (int c = 0; c < 640; c++) begin
            va = (c % 8 == 0) ? AW'(100) : AW'($urandom_range(0, PIXELS - 1));
            if (c < 4) tick(0, va, 1, 1, wa[c], wd[c]);
            else       tick(0, va, 0, 0, '0, '0);
            if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== va) bad_addr++;
            if (vgav_now && bus.vga_data !== vga_now) bad_pix++;
        end
        n_run++;
        if (bad_addr != 0) begin
            n_fail++;
            $display("FAIL disp_addr: %0d cycles where the RAM port did not follow vga_addr, required 0", bad_addr);
        end
        n_run++;
        if (bad_pix != 0) begin
            n_fail++;
            $display("FAIL disp_data: %0d cycles with wrong vga_data, required 0", bad_pix);
        end
        n_run++;
        if (bus.pending !== PW'(4)) begin
            n_fail++;
            $display("FAIL disp_queued: pending=%0d, required 4", bus.pending);
        end
        for (int k = 0; k < 4; k++) begin
            tick(1, '0, 0, 0, '0, '0);
            n_run++;
            if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== wa[k] || bus.ram_wdata !== wd[k]) begin
                n_fail++;
                $display("FAIL drain_write%0d: en=%b we=%b addr=%0d wdata=%h, required 1 1 %0d %h",
                         k, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, wa[k], wd[k]);
            end
        end
        tick(1, '0, 0, 0, '0, '0);
        n_run++;
        if (bus.pending !== PW'(0) || bus.ram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_done: pending=%0d ram_en=%b, required 0 0", bus.pending, bus.ram_en);
        end
    endtask

    task automatic test_full_fifo();
        req_t r [17];
        int k, bad;
        for (int i = 0; i < 17; i++) begin
            r[i].we = 1'($urandom_range(0, 1)); r[i].addr = AW'($urandom_range(0, 63)); r[i].wdata = DW'($urandom);
        end
        k = 0;
        for (int c = 0; c < 16; c++) begin
            tick(0, AW'(c), 1, r[k].we, r[k].addr, r[k].wdata);
            if (accepted) k++;
        end
        tick(0, '0, 1, r[16].we, r[16].addr, r[16].wdata);
        n_run++;
        if (bus.cpu_ready !== 1'b0 || bus.pending !== PW'(16)) begin
            n_fail++;
            $display("FAIL full_flag: ready=%b pending=%0d, required 0 16", bus.cpu_ready, bus.pending);
        end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick(0, '0, 1, r[16].we, r[16].addr, r[16].wdata);
            if (bus.cpu_ready !== 1'b0 || bus.pending !== PW'(16)) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL full_hold: %0d cycles not full while display busy, required 0", bad);
        end
        for (int c = 0; c < 17; c++) begin
            if (k < 17) tick(1, '0, 1, r[k].we, r[k].addr, r[k].wdata);
            else        tick(1, '0, 0, 0, '0, '0);
            if (accepted) k++;
            if (c == 0) begin
                n_run++;
                if (bus.cpu_ready !== 1'b0 || bus.pending !== PW'(16)) begin
                    n_fail++;
                    $display("FAIL full_pop_no_free: ready=%b pending=%0d, required 0 16", bus.cpu_ready, bus.pending);
                end
            end
            if (c == 1) begin
                n_run++;
                if (bus.cpu_ready !== 1'b1 || bus.pending !== PW'(15)) begin
                    n_fail++;
                    $display("FAIL full_accept17: ready=%b pending=%0d, required 1 15", bus.cpu_ready, bus.pending);
                end
            end
            n_run++;
            if (bus.ram_en !== 1'b1 || bus.ram_we !== r[c].we || bus.ram_addr !== r[c].addr) begin
                n_fail++;
                $display("FAIL full_order%0d: en=%b we=%b addr=%0d, required 1 %b %0d",
                         c, bus.ram_en, bus.ram_we, bus.ram_addr, r[c].we, r[c].addr);
            end
        end
        repeat (3) tick(1, '0, 0, 0, '0, '0);
        n_run++;
        if (bus.pending !== PW'(0) || bus.ram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drained: pending=%0d ram_en=%b, required 0 0", bus.pending, bus.ram_en);
        end
    endtask

    task automatic test_out_of_range();
        tick(1, '0, 1, 1, AW'(PIXELS), DW'(12'h555));
        tick(1, '0, 0, 0, '0, '0);
        n_run++;
        if (bus.cpu_err !== 1'b1 || bus.pending !== PW'(0) || bus.ram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_err: err=%b pending=%0d ram_en=%b, required 1 0 0", bus.cpu_err, bus.pending, bus.ram_en);
        end
        tick(1, '0, 1, 1, AW'(PIXELS - 1), DW'(12'h123));
        n_run++;
        if (bus.cpu_err !== 1'b0 || bus.ram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_pulse: err=%b ram_en=%b, required 0 0", bus.cpu_err, bus.ram_en);
        end
        tick(1, '0, 0, 0, '0, '0);
        n_run++;
        if (bus.cpu_err !== 1'b0 || bus.pending !== PW'(1) || bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1
            || bus.ram_addr !== AW'(PIXELS - 1)) begin
            n_fail++;
            $display("FAIL last_pixel: err=%b pending=%0d en=%b we=%b addr=%0d, required 0 1 1 1 %0d",
                     bus.cpu_err, bus.pending, bus.ram_en, bus.ram_we, bus.ram_addr, PIXELS - 1);
        end
    endtask

    task automatic test_reset_mid_read();
        tick(1, '0, 1, 1, AW'(5), DW'(12'h777));
        tick(1, '0, 1, 0, AW'(5), '0);
        tick(0, AW'(9), 1, 0, AW'(6), '0);
        tick(1, '0, 0, 0, '0, '0);
        n_run++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== AW'(5) || bus.pending !== PW'(2)) begin
            n_fail++;
            $display("FAIL rst_rd_issue: en=%b we=%b addr=%0d pending=%0d, required 1 0 5 2",
                     bus.ram_en, bus.ram_we, bus.ram_addr, bus.pending);
        end
        @(posedge vga_clk); #1;
        rst = 1'b1;
        set_idle();
        model_clear();
        @(negedge vga_clk);
        n_run++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== '0 || bus.pending !== PW'(0) || bus.cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid: rvalid=%b rdata=%h pending=%0d ready=%b, required 0 000 0 1",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.pending, bus.cpu_ready);
        end
        @(posedge vga_clk); #1;
        rst = 1'b0;
        @(negedge vga_clk);
        tick(1, '0, 0, 0, '0, '0);
        n_run++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== '0 || bus.ram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: rvalid=%b rdata=%h ram_en=%b, required 0 000 0",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.ram_en);
        end
    endtask

    task automatic test_random();
        logic          rdn, req, we;
        logic [AW-1:0] addr, va;
        int            run_left, sel;
        rdn = 1; run_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if (run_left == 0) begin
                rdn = ($urandom_range(0, 2) == 0);
                run_left = $urandom_range(1, 40);
            end
            run_left--;
            sel = $urandom_range(0, 15);
            if (sel == 0)      addr = AW'(PIXELS + $urandom_range(0, 3));
            else if (sel == 1) addr = AW'(PIXELS - 1);
            else               addr = AW'($urandom_range(0, 31));
            req = ($urandom_range(0, 2) != 0);
            we  = 1'($urandom_range(0, 1));
            va  = AW'($urandom_range(0, 31));
            tick(rdn, va, req, we, addr, DW'($urandom));
            n_run++;
            if (bus.cpu_ready !== e_ready || bus.pending !== PW'(e_pending) || bus.ram_en !== e_en
                || bus.ram_we !== e_we || bus.ram_addr !== e_addr || bus.ram_wdata !== e_wdata
                || bus.cpu_rvalid !== rv_now || bus.cpu_err !== err_now || bus.cpu_rdata !== rdata_now
                || (vgav_now && bus.vga_data !== vga_now)) begin
                n_fail++;
                $display("FAIL random cyc%0d got/req: ready %b/%b pending %0d/%0d en %b/%b we %b/%b addr %h/%h wdata %h/%h rvalid %b/%b err %b/%b rdata %h/%h vga %h/%h",
                         c, bus.cpu_ready, e_ready, bus.pending, e_pending, bus.ram_en, e_en, bus.ram_we, e_we,
                         bus.ram_addr, e_addr, bus.ram_wdata, e_wdata, bus.cpu_rvalid, rv_now, bus.cpu_err, err_now,
                         bus.cpu_rdata, rdata_now, bus.vga_data, vga_now);
            end
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        test_reset();
        test_blank_write_read();
        test_display_priority();
        test_full_fifo();
        test_out_of_range();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
